despachante_troco: RTL and testbench
====================================

// Module: despachante_troco
// PURPOSE
//  Sequences the coin-ejector mechanism when the vending machine returns change.
//  Reads the change value and a snapshot of the wallet coin inventory, then plans
//  the coins to use (largest first: R$1,00, R$0,50, R$0,25).
//  Drives the ejector one coin at a time over a 4-phase req/ack handshake.
//  Reports coins used, completion, or an error code.
//  Sits between the sale FSM (which issues iniciar) and the physical ejector.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles to wait for each ejector_ack edge before abort (>=1)
// PORTS
//  clock            in   1   system clock, all logic on rising edge
//  reset            in   1   asynchronous, active-high reset
//  iniciar          in   1   start pulse; sampled only in OCIOSO
//  valor_troco      in   8   change value in centavos (multiple of 25 expected)
//  moedas_carteira  in   24  inventory: [7:0]=25c, [15:8]=50c, [23:16]=100c
//  ejetar           out  3   one-hot coin request: [0]=25c, [1]=50c, [2]=100c
//  ejetor_ack       in   1   ejector acknowledge (4-phase)
//  ocupado          out  1   high from cycle after accepted iniciar until FIM/ERRO exit
//  concluido        out  1   1-cycle pulse: all planned coins ejected
//  erro             out  2   00 none, 01 exact change impossible, 10 ejector timeout
//  moedas_usadas    out  24  coins ejected so far, same packing as moedas_carteira
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=OCIOSO.
//   - ejetar=0, ocupado=0, concluido=0, erro=0, moedas_usadas=0, plan/rem/timer=0.
//   - Reset mid-ejection drops ejetar at once; no coin is counted.
//  Capture:
//   - In OCIOSO, iniciar=1 at edge T latches valor_troco->rem and the inventory.
//   - Same edge: clears moedas_usadas and erro; ocupado=1 from T.
//   - iniciar while ocupado=1 is ignored.
//  States:
//   - OCIOSO.
//   - P100 (T+1): n100=min(inv100, rem/100); rem-=100*n100.
//   - P50  (T+2): n50 =min(inv50,  rem/50);  rem-=50*n50.
//   - P25  (T+3): n25 =min(inv25,  rem/25);  rem-=25*n25.
//   - VERIFICA (T+4):
//       rem!=0 -> ERRO with erro=01; no coin ejected.
//       rem==0 and all n==0 -> FIM.
//       otherwise -> REQ.
//     Greedy is exact-feasible because the denominations form a divisible chain.
//   - REQ:
//       ejetar = one-hot of the largest denomination with n>0 (registered output).
//       Hold until ejetor_ack=1.
//       On ack: ejetar=0, n-=1, increment moedas_usadas field; go to SOLTA.
//   - SOLTA:
//       Wait ejetor_ack=0.
//       Then -> REQ if any n>0, else -> FIM.
//   - Timeout:
//       Timer reloads on entry to REQ and to SOLTA.
//       Reaching TIMEOUT_CYCLES without the awaited ack level -> ERRO, erro=10, ejetar=0.
//   - FIM:
//       concluido=1 for one cycle; ocupado=0 next cycle -> OCIOSO.
//   - ERRO:
//       One cycle -> OCIOSO, ocupado=0.
//       erro holds until next accepted iniciar or reset.
//  Arithmetic and widths:
//   - 8-bit unsigned throughout; rem never underflows because n is bounded by rem/denom.
//   - valor_troco=0 -> concluido at T+5, moedas_usadas=0.
//   - moedas_usadas fields are 8-bit and cannot exceed the latched inventory.
//  Handshake:
//   - Never two ejetar bits high at once.
//   - A new request never starts while ejetor_ack=1.
//  Inventory is not updated here; the sale FSM subtracts moedas_usadas after concluido.
// TESTING
//  1. valor=75, inv {100:2,50:1,25:1}, ack 2 cycles after req -> ejetar 010 then 001;
//     concluido; moedas_usadas=0x000101.
//  2. valor=100, inv {100:0,50:1,25:2} -> sequence 50,25,25; moedas_usadas=0x000102.
//  3. valor=75, inv {100:3,50:0,25:2} -> erro=01 at T+5; ejetar never asserted.
//  4. valor=0 -> concluido pulse at T+5, erro=00, no ejetar activity.
//  5. valor=50, ack never rises, TIMEOUT_CYCLES=8 -> ejetar=010 for 8 cycles, then 0;
//     erro=10; ocupado=0.
//  6. Reset asserted while ejetar=100 -> all outputs 0 same cycle;
//     iniciar after release accepted; iniciar pulses while ocupado=1 ignored.

Source files
------------

// File: rtl/despachante_troco.sv
// Change dispenser sequencer: plans coins greedily (100/50/25 centavos) from a
// latched inventory snapshot and drives the ejector one coin at a time over a 4-phase req/ack.
module despachante_troco #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [7:0]  valor_troco,
  input  logic [23:0] moedas_carteira,
  output logic [2:0]  ejetar,
  input  logic        ejetor_ack,
  output logic        ocupado,
  output logic        concluido,
  output logic [1:0]  erro,
  output logic [23:0] moedas_usadas
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    OCIOSO, P100, P50, P25, VERIFICA, REQ, SOLTA, FIM, ERRO
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      rem;
  logic [2:0][7:0] inv;   // index 0=25c, 1=50c, 2=100c, same packing as the ports
  logic [2:0][7:0] n;     // coins still to eject per denomination
  logic [2:0][7:0] used;
  logic [TW-1:0]   timer;
  logic [7:0]      take100, take50, take25;
  logic            any_n, timeout;

  function automatic logic [7:0] take(input logic [7:0] r, input logic [7:0] avail,
                                      input logic [7:0] denom);
    logic [7:0] q;
    q = r / denom;
    return (avail < q) ? avail : q;
  endfunction

  function automatic logic [2:0] largest(input logic [2:0][7:0] cnt);
    if (cnt[2] != 8'd0) return 3'b100;
    if (cnt[1] != 8'd0) return 3'b010;
    if (cnt[0] != 8'd0) return 3'b001;
    return 3'b000;
  endfunction

  assign take100 = take(rem, inv[2], 8'd100);
  assign take50  = take(rem, inv[1], 8'd50);
  assign take25  = take(rem, inv[0], 8'd25);
  assign any_n   = |n;
  assign timeout = (timer == TIMER_LAST);
  assign moedas_usadas = used;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= OCIOSO;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      OCIOSO:   if (iniciar) state_nx = P100;
      P100:     state_nx = P50;
      P50:      state_nx = P25;
      P25:      state_nx = VERIFICA;
      VERIFICA: begin
        if (rem != 8'd0) state_nx = ERRO;
        else if (any_n)  state_nx = REQ;
        else             state_nx = FIM;
      end
      REQ: begin
        if (ejetor_ack)   state_nx = SOLTA;
        else if (timeout) state_nx = ERRO;
      end
      SOLTA: begin
        if (!ejetor_ack)  state_nx = any_n ? REQ : FIM;
        else if (timeout) state_nx = ERRO;
      end
      FIM, ERRO: state_nx = OCIOSO;
      default:   state_nx = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado   = (state != OCIOSO);
    concluido = (state == FIM);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem    <= '0;
      inv    <= '0;
      n      <= '0;
      used   <= '0;
      timer  <= '0;
      ejetar <= '0;
      erro   <= '0;
    end else begin
      case (state)
        OCIOSO: if (iniciar) begin
          rem  <= valor_troco;
          inv  <= moedas_carteira;
          n    <= '0;
          used <= '0;
          erro <= 2'b00;
        end
        P100: begin
          n[2] <= take100;
          rem  <= rem - take100 * 8'd100;
        end
        P50: begin
          n[1] <= take50;
          rem  <= rem - take50 * 8'd50;
        end
        P25: begin
          n[0] <= take25;
          rem  <= rem - take25 * 8'd25;
        end
        VERIFICA: begin
          if (rem != 8'd0) erro <= 2'b01;
          else if (any_n) begin
            ejetar <= largest(n);
            timer  <= '0;
          end
        end
        REQ: begin
          if (ejetor_ack) begin
            ejetar <= 3'b000;
            timer  <= '0;
            for (int i = 0; i < 3; i++) begin
              if (ejetar[i]) begin
                n[i]    <= n[i] - 8'd1;
                used[i] <= used[i] + 8'd1;
              end
            end
          end else if (timeout) begin
            ejetar <= 3'b000;
            erro   <= 2'b10;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SOLTA: begin
          // Next request only after the ejector has released ack.
          if (!ejetor_ack) begin
            if (any_n) begin
              ejetar <= largest(n);
              timer  <= '0;
            end
          end else if (timeout) begin
            erro <= 2'b10;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_despachante_troco.sv
// Directed bench for despachante_troco: expected coin requests are queued per
// scenario and checked by a behavioural ejector as requests appear.
module tb_despachante_troco;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic [7:0]  valor_troco = '0;
  logic [23:0] moedas_carteira = '0;
  logic [2:0]  ejetar;
  logic        ejetor_ack = 1'b0;
  logic        ocupado;
  logic        concluido;
  logic [1:0]  erro;
  logic [23:0] moedas_usadas;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] sb_q[$];
  int ack_delay = 2;
  bit ack_never = 1'b0;

  despachante_troco #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .valor_troco(valor_troco),
    .moedas_carteira(moedas_carteira),
    .ejetar(ejetar),
    .ejetor_ack(ejetor_ack),
    .ocupado(ocupado),
    .concluido(concluido),
    .erro(erro),
    .moedas_usadas(moedas_usadas)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Ejector model: pops the expected coin on each new request, acks after
  // ack_delay cycles, releases ack once the request drops.
  initial begin
    int wait_cnt;
    bit seen;
    logic [2:0] exp_coin;
    wait_cnt = 0;
    seen = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ejetor_ack = 1'b0;
        seen = 1'b0;
        wait_cnt = 0;
      end else if (!ejetor_ack) begin
        if (ejetar == 3'b000) seen = 1'b0;
        else begin
          if (!seen) begin
            seen = 1'b1;
            wait_cnt = 0;
            if (sb_q.size() == 0) check("unexpected_ejetar", ejetar, 3'b000);
            else begin
              exp_coin = sb_q.pop_front();
              check("ejetar_coin", ejetar, exp_coin);
            end
          end
          wait_cnt++;
          if (!ack_never && wait_cnt >= ack_delay) ejetor_ack = 1'b1;
        end
      end else if (ejetar == 3'b000) begin
        ejetor_ack = 1'b0;
        seen = 1'b0;
      end
    end
  end

  // Pulses iniciar, then samples each negedge after the capture edge (k=0)
  // until ocupado falls. Optional spurious iniciar at k=1 must be ignored.
  task automatic run(input logic [7:0] valor, input logic [23:0] inv, input bit spur,
                     input int budget, output int done_k, output int done_cnt,
                     output int err_k, output int ej_cycles);
    valor_troco = valor;
    moedas_carteira = inv;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("ocupado_after_start", ocupado, 1);
    check("erro_cleared_on_start", erro, 0);
    done_k = -1;
    done_cnt = 0;
    err_k = -1;
    ej_cycles = 0;
    for (int k = 0; k <= budget; k++) begin
      if (k > 0) @(negedge clock);
      if (concluido) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (erro != 2'b00 && err_k < 0) err_k = k;
      if (ejetar != 3'b000) ej_cycles++;
      if (spur && k == 1) begin
        iniciar = 1'b1;
        valor_troco = 8'd100;
        moedas_carteira = 24'h010000;
      end else begin
        iniciar = 1'b0;
      end
      if (!ocupado) return;
    end
    check("run_bounded", ocupado, 0);
  endtask

  initial begin
    int dk, dc, ek, ec;

    repeat (3) @(negedge clock);
    check("rst_ejetar", ejetar, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_concluido", concluido, 0);
    check("rst_erro", erro, 0);
    check("rst_usadas", moedas_usadas, 0);
    reset = 1'b0;
    @(negedge clock);

    // 1: 75 with {100:2,50:1,25:1} -> 50 then 25
    ack_delay = 2;
    sb_q.push_back(3'b010);
    sb_q.push_back(3'b001);
    run(8'd75, 24'h020101, 1'b0, 60, dk, dc, ek, ec);
    check("t1_concluido_cnt", dc, 1);
    check("t1_erro", erro, 0);
    check("t1_usadas", moedas_usadas, 24'h000101);
    check("t1_sb_drained", sb_q.size(), 0);

    // 2: 100 with {100:0,50:1,25:2} -> 50, 25, 25
    ack_delay = 1;
    sb_q.push_back(3'b010);
    sb_q.push_back(3'b001);
    sb_q.push_back(3'b001);
    run(8'd100, 24'h000102, 1'b0, 60, dk, dc, ek, ec);
    check("t2_concluido_cnt", dc, 1);
    check("t2_erro", erro, 0);
    check("t2_usadas", moedas_usadas, 24'h000102);
    check("t2_sb_drained", sb_q.size(), 0);

    // 3: 75 with {100:3,50:0,25:2} -> exact change impossible
    run(8'd75, 24'h030002, 1'b0, 30, dk, dc, ek, ec);
    check("t3_erro_k", ek, 4);
    check("t3_erro", erro, 2'b01);
    check("t3_no_concluido", dc, 0);
    check("t3_no_ejetar", ec, 0);
    check("t3_usadas", moedas_usadas, 0);

    // 4: zero change -> concluido at T+5
    run(8'd0, 24'h050505, 1'b0, 30, dk, dc, ek, ec);
    check("t4_concluido_k", dk, 4);
    check("t4_concluido_cnt", dc, 1);
    check("t4_erro", erro, 0);
    check("t4_no_ejetar", ec, 0);
    check("t4_usadas", moedas_usadas, 0);

    // 5: ack never rises -> 8-cycle request then timeout
    ack_never = 1'b1;
    sb_q.push_back(3'b010);
    run(8'd50, 24'h000100, 1'b0, 60, dk, dc, ek, ec);
    check("t5_ejetar_cycles", ec, 8);
    check("t5_erro", erro, 2'b10);
    check("t5_ocupado", ocupado, 0);
    check("t5_ejetar_low", ejetar, 0);
    check("t5_no_concluido", dc, 0);
    check("t5_usadas", moedas_usadas, 0);
    check("t5_sb_drained", sb_q.size(), 0);

    // 6: reset during a 100c request, then restart with spurious iniciar
    sb_q.push_back(3'b100);
    valor_troco = 8'd100;
    moedas_carteira = 24'h010000;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    for (int i = 0; i < 20 && ejetar != 3'b100; i++) @(negedge clock);
    check("t6_req_100", ejetar, 3'b100);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_ejetar", ejetar, 0);
    check("t6_rst_ocupado", ocupado, 0);
    check("t6_rst_concluido", concluido, 0);
    check("t6_rst_erro", erro, 0);
    check("t6_rst_usadas", moedas_usadas, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    ack_never = 1'b0;
    ack_delay = 1;
    sb_q.push_back(3'b001);
    run(8'd25, 24'h000001, 1'b1, 40, dk, dc, ek, ec);
    check("t6_concluido_cnt", dc, 1);
    check("t6_erro", erro, 0);
    check("t6_usadas", moedas_usadas, 24'h000001);
    check("t6_sb_drained", sb_q.size(), 0);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
